// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch sequencer, consumer end of the PC-register interface.
// Samples dnpc, issues one valid/ready memory read, holds the returned word for
// decode, and strobes pc_wen back to the PC register when decode accepts it.
// Exactly one instruction is in flight at any time.
// Optional feature: define IFU_MISALIGN_EN to turn a misaligned pc into a
// faulting NOP instead of a memory fetch.
module ifu_fetch #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en,
   input  logic              flush,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_wen,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_resp_valid,
   output logic              mem_resp_ready,
   input  logic [DATA_W-1:0] mem_resp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_fault
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DRAIN,
      S_HOLD
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [DATA_W-1:0] r_inst;
   logic [ADDR_W-1:0] r_inst_pc;
   logic              w_start;      // IDLE accepts a new fetch this cycle
   logic              w_issue;      // IDLE goes to REQ (normal memory fetch)
   logic              w_cap_mem;    // WAIT captures the memory response
`ifdef IFU_MISALIGN_EN
   logic              r_fault;
   logic              w_misalign;
   logic              w_cap_fault;  // IDLE synthesises a faulting NOP
`endif

   // Next-state and handshake outputs; all defaults assigned first.
   always_comb begin
      w_next         = r_state;
      w_start        = 1'b0;
      w_issue        = 1'b0;
      w_cap_mem      = 1'b0;
      mem_req_valid  = 1'b0;
      mem_resp_ready = 1'b0;
      inst_valid     = 1'b0;
      pc_wen         = 1'b0;
`ifdef IFU_MISALIGN_EN
      w_misalign     = (pc[1:0] != 2'b00);
      w_cap_fault    = 1'b0;
`endif
      unique case (r_state)
         S_IDLE: begin
            w_start = fetch_en & ~flush;
`ifdef IFU_MISALIGN_EN
            w_cap_fault = w_start & w_misalign;
            w_issue     = w_start & ~w_misalign;
            if (w_cap_fault) w_next = S_HOLD;
`else
            w_issue = w_start;
`endif
            if (w_issue) w_next = S_REQ;
         end
         S_REQ: begin
            mem_req_valid = 1'b1;
            // A flush before acceptance withdraws the request; once accepted,
            // the response must still be collected, which WAIT/DRAIN handle.
            if (mem_req_ready)  w_next = S_WAIT;
            else if (flush)     w_next = S_IDLE;
         end
         S_WAIT: begin
            mem_resp_ready = 1'b1;
            // A response arriving together with a flush has already been
            // consumed, so discard it and go straight to IDLE rather than DRAIN.
            if (mem_resp_valid) begin
               w_cap_mem = ~flush;
               w_next    = flush ? S_IDLE : S_HOLD;
            end else if (flush) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            mem_resp_ready = 1'b1;
            if (mem_resp_valid) w_next = S_IDLE;
         end
         S_HOLD: begin
            inst_valid = 1'b1;
            pc_wen     = inst_ready & ~flush;
            if (flush | inst_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State register plus fetch address and instruction holding registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= '0;
         r_inst     <= '0;
         r_inst_pc  <= '0;
`ifdef IFU_MISALIGN_EN
         r_fault    <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         if (w_issue) r_fetch_pc <= pc;
         if (w_cap_mem) begin
            r_inst    <= mem_resp_data;
            r_inst_pc <= r_fetch_pc;
`ifdef IFU_MISALIGN_EN
            r_fault   <= 1'b0;
`endif
         end
`ifdef IFU_MISALIGN_EN
         if (w_cap_fault) begin
            r_inst    <= DATA_W'(32'h0000_0013);
            r_inst_pc <= pc;
            r_fault   <= 1'b1;
         end
`endif
      end
   end

   assign mem_req_addr = r_fetch_pc;
   assign inst         = r_inst;
   assign inst_pc      = r_inst_pc;
`ifdef IFU_MISALIGN_EN
   assign inst_fault   = r_fault;
`else
   assign inst_fault   = 1'b0;
`endif

endmodule
